saturation_signed_divide: RTL and testbench

Iterative signed divider, the inverse of the team's saturating signed multiplier. It computes out = (a << OFFSET) / b, truncated toward zero, and saturates the result to OUT_SIZE bits. Restoring algorithm, one quotient bit per clock, with a start/busy/valid handshake. Used in the fixed-point math path (brightness and scale normalisation) where one result every few dozen cycles is sufficient.

---
 rtl/saturation_signed_divide.sv | 168 ++++++++++++++++
 tb/tb_saturation_signed_divide.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturation_signed_divide.sv
// saturation_signed_divide
//   Iterative restoring signed divider: out = (a << OFFSET) / b, truncated
//   toward zero and saturated to OUT_SIZE bits. One quotient bit per clock.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      request a division; accepted only while busy=0
//   a          signed dividend, sampled on the accepting edge
//   b          signed divisor, sampled on the accepting edge
//   busy       high from the accepting edge until out_valid rises
//   out        signed saturated quotient, held until the next result
//   rem        signed remainder (sign of a); 0 on divide-by-zero or saturation
//   out_valid  one-cycle pulse when out/rem/sat/div_zero update
//   sat        result clipped, or divide-by-zero; held with out
//   div_zero   divisor was zero; held with out
module saturation_signed_divide #(
  parameter int A_SIZE   = 8,
  parameter int B_SIZE   = 4,
  parameter int OFFSET   = 0,
  parameter int OUT_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [A_SIZE-1:0]   a,
  input  logic signed [B_SIZE-1:0]   b,
  output logic                       busy,
  output logic signed [OUT_SIZE-1:0] out,
  output logic signed [B_SIZE-1:0]   rem,
  output logic                       out_valid,
  output logic                       sat,
  output logic                       div_zero
);

  localparam int N  = A_SIZE + OFFSET;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough to compare the quotient magnitude against 2^(OUT_SIZE-1)
  // whichever of N and OUT_SIZE is larger.
  localparam int QW = ((N > OUT_SIZE) ? N : OUT_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e            state_q;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at
  // the LSB, so after N iterations this register holds the quotient.
  logic [N-1:0]      dvd_q;
  logic [B_SIZE-1:0] prem_q;
  logic [B_SIZE-1:0] bmag_q;
  logic [CW-1:0]     cnt_q;
  logic              aneg_q;
  logic              qneg_q;
  logic              bzero_q;

  logic [A_SIZE-1:0]   amag_d;
  logic [B_SIZE-1:0]   bmag_d;
  logic [N-1:0]        dvd_d;
  logic [B_SIZE-1:0]   shifted;
  logic [B_SIZE-1:0]   diff;
  logic                ge;
  logic [QW-1:0]       qmag;
  logic [QW-1:0]       maxp;
  logic [QW-1:0]       minn_mag;
  logic [OUT_SIZE-1:0] out_d;
  logic [B_SIZE-1:0]   rem_d;
  logic                sat_d;

  // Magnitudes of the inputs. |most negative| lands exactly on the MSB of an
  // unsigned word of the same width, so no extra bit is needed.
  always_comb begin
    amag_d = a[A_SIZE-1] ? (~a + A_SIZE'(1)) : a;
    bmag_d = b[B_SIZE-1] ? (~b + B_SIZE'(1)) : b;
    dvd_d  = N'(amag_d) << OFFSET;
  end

  // One restoring step. The partial remainder is always < |b| <= 2^(B_SIZE-1),
  // so its top bit is zero and the shifted value still fits in B_SIZE bits.
  // With b=0 the values are garbage but the result is overridden in FIX.
  always_comb begin
    shifted = {prem_q[B_SIZE-2:0], dvd_q[N-1]};
    ge      = (shifted >= bmag_q);
    diff    = shifted - bmag_q;
  end

  // Sign application and saturation on the finished quotient.
  always_comb begin
    qmag     = QW'(dvd_q);
    maxp     = (QW'(1) << (OUT_SIZE - 1)) - QW'(1);
    minn_mag = QW'(1) << (OUT_SIZE - 1);
    out_d    = '0;
    rem_d    = '0;
    sat_d    = 1'b0;
    if (bzero_q) begin
      out_d = aneg_q ? minn_mag[OUT_SIZE-1:0] : maxp[OUT_SIZE-1:0];
      sat_d = 1'b1;
    end else if (!qneg_q && (qmag > maxp)) begin
      out_d = maxp[OUT_SIZE-1:0];
      sat_d = 1'b1;
    end else if (qneg_q && (qmag > minn_mag)) begin
      out_d = minn_mag[OUT_SIZE-1:0];
      sat_d = 1'b1;
    end else begin
      // A zero magnitude negates to zero, so no negative zero appears.
      out_d = qneg_q ? (~qmag[OUT_SIZE-1:0] + OUT_SIZE'(1)) : qmag[OUT_SIZE-1:0];
      rem_d = aneg_q ? (~prem_q + B_SIZE'(1)) : prem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      prem_q    <= '0;
      bmag_q    <= '0;
      cnt_q     <= '0;
      aneg_q    <= 1'b0;
      qneg_q    <= 1'b0;
      bzero_q   <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            aneg_q  <= a[A_SIZE-1];
            qneg_q  <= a[A_SIZE-1] ^ b[B_SIZE-1];
            bzero_q <= (b == '0);
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            prem_q  <= '0;
            cnt_q   <= CW'(N - 1);
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          dvd_q  <= {dvd_q[N-2:0], ge};
          prem_q <= ge ? diff : shifted;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          out       <= out_d;
          rem       <= rem_d;
          sat       <= sat_d;
          div_zero  <= bzero_q;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saturation_signed_divide.sv
// tb_saturation_signed_divide
//   Self-checking bench for saturation_signed_divide. A default-parameter
//   instance is driven through a scoreboard queue (expected result and due
//   cycle pushed at issue, popped when out_valid rises); a second instance
//   with OFFSET=4 covers Q-format scaling.
module tb_saturation_signed_divide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic signed [7:0] a;
  logic signed [3:0] b;
  logic              busy;
  logic signed [7:0] out;
  logic signed [3:0] rem;
  logic              out_valid;
  logic              sat;
  logic              div_zero;

  logic              start2;
  logic signed [7:0] a2;
  logic signed [3:0] b2;
  logic              busy2;
  logic signed [7:0] out2;
  logic signed [3:0] rem2;
  logic              ov2;
  logic              sat2;
  logic              dz2;

  saturation_signed_divide #(
    .A_SIZE(8), .B_SIZE(4), .OFFSET(0), .OUT_SIZE(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .out(out), .rem(rem), .out_valid(out_valid),
    .sat(sat), .div_zero(div_zero)
  );

  saturation_signed_divide #(
    .A_SIZE(8), .B_SIZE(4), .OFFSET(4), .OUT_SIZE(8)
  ) u_q4 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .out(out2), .rem(rem2), .out_valid(ov2),
    .sat(sat2), .div_zero(dz2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit s;
    bit z;
  } vec_t;

  typedef struct {
    logic [13:0] res;
    int          due;
    int          tag;
  } sb_t;

  sb_t sbq[$];
  sb_t mon_e;

  function automatic logic [13:0] pack(input int q, input int r, input bit s, input bit z);
    logic [7:0] q8;
    logic [3:0] r4;
    q8 = 8'(q);
    r4 = 4'(r);
    return {q8, r4, s, z};
  endfunction

  // Truncating reference: integer division in SV rounds toward zero and the
  // remainder takes the dividend's sign.
  function automatic void ref_model(input int av, input int bv, input int off,
                                    output int q, output int r, output bit s, output bit z);
    int as;
    as = av * (1 << off);
    s  = 0;
    z  = 0;
    if (bv == 0) begin
      z = 1;
      s = 1;
      r = 0;
      q = (av >= 0) ? 127 : -128;
    end else begin
      q = as / bv;
      r = as % bv;
      if (q > 127) begin
        q = 127; r = 0; s = 1;
      end else if (q < -128) begin
        q = -128; r = 0; s = 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // Scoreboard consumer for the default instance.
  always begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", cyc, 32'(out_valid), 32'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("result{out,rem,sat,dz}", mon_e.tag, 32'({out, rem, sat, div_zero}), 32'(mon_e.res));
        chk("latency_cycle", mon_e.tag, cyc, mon_e.due);
      end
    end
  end

  task automatic issue(input int av, input int bv, input logic [13:0] er, input int tag,
                       input bit expect_ov);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("issue_busy_timeout", tag, 32'(busy), 32'(0));
    if (expect_ov) chk("accept_in_valid_cycle", tag, 32'(out_valid), 32'(1));
    a     = 8'(av);
    b     = 4'(bv);
    start = 1'b1;
    sbq.push_back('{er, cyc + 10, tag});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 32'(sbq.size()), 32'(0));
      sbq.delete();
    end
  endtask

  task automatic qrun(input vec_t v, input int tag);
    int t0;
    int k;
    @(negedge clk);
    a2     = 8'(v.a);
    b2     = 4'(v.b);
    start2 = 1'b1;
    t0     = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      if (ov2) break;
      k++;
    end
    if (!ov2) begin
      chk("q4_valid_timeout", tag, 32'(ov2), 32'(1));
    end else begin
      chk("q4_result{out,rem,sat,dz}", tag, 32'({out2, rem2, sat2, dz2}),
          32'(pack(v.q, v.r, v.s, v.z)));
      chk("q4_latency", tag, cyc - t0, 13);
    end
  endtask

  vec_t tbl[13];
  vec_t qtbl[8];

  initial begin
    int q;
    int r;
    bit s;
    bit z;
    int seen;

    tbl = '{
      '{ 100,  7,   14,  2, 0, 0},
      '{-100,  7,  -14, -2, 0, 0},
      '{ 100, -7,  -14,  2, 0, 0},
      '{-100, -7,   14, -2, 0, 0},
      '{-128, -1,  127,  0, 1, 0},
      '{-128,  1, -128,  0, 0, 0},
      '{   5,  0,  127,  0, 1, 1},
      '{  -5,  0, -128,  0, 1, 1},
      '{  -3,  7,    0, -3, 0, 0},
      '{ 127, -8,  -15,  7, 0, 0},
      '{-128, -8,   16,  0, 0, 0},
      '{   0,  0,  127,  0, 1, 1},
      '{-128,  7,  -18, -2, 0, 0}
    };
    qtbl = '{
      '{ 3,  2,   24,  0, 0, 0},
      '{ 7,  1,  112,  0, 0, 0},
      '{ 8,  1,  127,  0, 1, 0},
      '{-8,  1, -128,  0, 0, 0},
      '{-3,  7,   -6, -6, 0, 0},
      '{ 5, -3,  -26,  2, 0, 0},
      '{-9,  1, -128,  0, 1, 0},
      '{ 1,  0,  127,  0, 1, 1}
    };

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 0, 32'({busy, out, rem, out_valid, sat, div_zero}), 32'(0));
    chk("reset_state_q4", 0, 32'({busy2, out2, rem2, ov2, sat2, dz2}), 32'(0));
    rst = 1'b0;

    // Table vectors, issued back to back.
    foreach (tbl[i]) issue(tbl[i].a, tbl[i].b, pack(tbl[i].q, tbl[i].r, tbl[i].s, tbl[i].z), i, 1'b0);
    drain();

    // start while busy with different operands must be ignored.
    issue(100, 7, pack(14, 2, 0, 0), 100, 1'b0);
    @(negedge clk);
    a = -8'sd50; b = 4'sd3; start = 1'b1;
    chk("busy_when_ignored_start", 100, 32'(busy), 32'(1));
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    drain();

    // Back-to-back: second start lands in the out_valid cycle of the first.
    issue(-100, 7, pack(-14, -2, 0, 0), 200, 1'b0);
    issue(127, -8, pack(-15, 7, 0, 0), 201, 1'b1);
    drain();

    // Reset during iteration 4 aborts the operation.
    @(negedge clk);
    a = 8'sd100; b = 4'sd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_abort_outputs", 300, 32'({busy, out, rem, out_valid, sat, div_zero}), 32'(0));
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no_valid_after_abort", 300, seen, 0);
    issue(50, -3, pack(-16, 2, 0, 0), 301, 1'b0);
    drain();

    // Exhaustive sweep against the reference model.
    for (int ai = -128; ai <= 127; ai++) begin
      for (int bi = -8; bi <= 7; bi++) begin
        ref_model(ai, bi, 0, q, r, s, z);
        issue(ai, bi, pack(q, r, s, z), (ai + 128) * 16 + (bi + 8), 1'b0);
      end
    end
    drain();

    // Q-format instance.
    foreach (qtbl[i]) qrun(qtbl[i], 500 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
